shift_rotate_ctrl: RTL
======================

SHIFT_ROTATE_CTRL -- requirements
Module: shift_rotate_ctrl

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; SHALL be a power of two, at least 2; LOG2W = log2(WIDTH).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: clr  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  request a new operation; sampled on rising edge.
REQ-005 Port: op  input  3  operation code: 000 ROL, 001 ROR, 010 SHL, 011 SHR (logical), 100 SHRA (arithmetic); 101-111 illegal.
REQ-006 Port: a  input  WIDTH  operand to shift/rotate.
REQ-007 Port: b  input  WIDTH  shift/rotate amount, unsigned.
REQ-008 Port: busy  output  1  high while the operation is in progress.
REQ-009 Port: done  output  1  one-cycle pulse; result valid.
REQ-010 Port: err  output  1  illegal op flag, valid with done.
REQ-011 Port: result  output  WIDTH  operation result, held until the next accepted start or clr.

Function
REQ-012 FSM states: IDLE, RUN, DONE; exactly one active.
REQ-013 start SHALL be accepted only in IDLE or DONE; start in RUN SHALL be ignored and SHALL not disturb captured state.
REQ-014 On acceptance: capture a into the working register, op, amt = b[LOG2W-1:0], over = (b >= WIDTH); clear the stage counter; go to RUN.
REQ-015 RUN lasts exactly LOG2W cycles; in stage k (k = 0..LOG2W-1), if amt[k] = 1, move the working register by 2^k positions per op; otherwise hold it.
REQ-016 ROL/ROR SHALL use amt only, so the amount is b mod WIDTH; bits leaving one end enter the other.
REQ-017 SHL/SHR SHALL fill vacated bits with 0.
REQ-018 SHRA SHALL fill vacated bits with the captured a[WIDTH-1].
REQ-019 For shifts with over = 1: result SHALL be all-zero (SHL/SHR) or all copies of a[WIDTH-1] (SHRA), irrespective of amt.
REQ-020 Latency is fixed: start accepted at edge n -> done = 1 in the cycle after edge n+LOG2W (for WIDTH = 32, 5 cycles), independent of amount (including 0).
REQ-021 After the last RUN stage, go to DONE: result updates and done = 1 for exactly one cycle.
REQ-022 DONE with no start -> IDLE. DONE with start -> accept (REQ-014) and go to RUN, giving back-to-back throughput of one operation per LOG2W+1 cycles.
REQ-023 busy SHALL be 1 in RUN only; done SHALL be 1 in DONE only; they are never both 1.
REQ-024 Illegal op: run full latency; result = captured a unchanged; err = 1 during the done cycle and held with result; err = 0 for legal ops.
REQ-025 result and err SHALL change only at the DONE transition or on clr; result never shows intermediate stage values.

Reset
REQ-026 clr = 1 at an edge: state IDLE; busy, done, err = 0; result = 0; working register, amt, over, and stage counter cleared.
REQ-027 clr SHALL take priority over start and over any in-progress RUN; the aborted operation SHALL produce no done pulse.
REQ-028 start asserted together with clr SHALL be ignored.

Verification
REQ-029 ROL, a=0x80000001, b=1 -> done at cycle n+5, result=0x00000003, err=0.
REQ-030 ROR, a=0x00000001, b=36 -> result=0x10000000 (amount 4); ROL, b=0 -> result=a, still 5-cycle latency.
REQ-031 SHRA, a=0xF0000000, b=40 -> 0xFFFFFFFF. SHR, same operands -> 0x00000000. SHRA, a=0x80000000, b=4 -> 0xF8000000.
REQ-032 ROL a=0x1 b=8, then start with different operands during RUN -> ignored, result=0x00000100. Start in the DONE cycle -> accepted, next done exactly 6 cycles later.
REQ-033 clr asserted in the 3rd RUN cycle -> next cycle busy=0, done=0, result=0, no done pulse. A subsequent SHL a=0x1 b=31 -> 0x80000000.
REQ-034 op=3'b111, a=0x12345678 -> done with err=1, result=0x12345678. A following legal op clears err to 0.

Source files
------------

// File: rtl/shift_rotate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : shift_rotate_ctrl
// Description : Multi-cycle barrel shifter/rotator. Each accepted operation
//               runs one binary-weighted stage per cycle (LOG2W stages), then
//               publishes result/err with a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_rotate_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    localparam int LOG2W = $clog2(WIDTH);

    // State encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Operation codes
    localparam logic [2:0] c_op_rol  = 3'b000;
    localparam logic [2:0] c_op_ror  = 3'b001;
    localparam logic [2:0] c_op_shl  = 3'b010;
    localparam logic [2:0] c_op_shr  = 3'b011;
    localparam logic [2:0] c_op_shra = 3'b100;

    localparam logic [LOG2W-1:0] c_last_stage = LOG2W'(LOG2W - 1);
    localparam logic [LOG2W:0]   c_width      = (LOG2W + 1)'(WIDTH);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [WIDTH-1:0] r_work;
    logic [2:0]       r_op;
    logic [LOG2W-1:0] r_amt;
    logic             r_over;
    logic [LOG2W-1:0] r_stage;
    logic [WIDTH-1:0] r_result;
    logic             r_err;

    logic             w_accept;
    logic             w_last;
    logic             w_illegal;
    logic [LOG2W:0]   w_step;
    logic [LOG2W:0]   w_rstep;
    logic [WIDTH-1:0] w_moved;
    logic [WIDTH-1:0] w_stage_out;
    logic [WIDTH-1:0] w_final;

    // A new request is taken whenever the engine is not mid-operation;
    // clr overrides it inside the sequential blocks.
    assign w_accept  = start && (r_state != S_RUN);
    assign w_last    = (r_state == S_RUN) && (r_stage == c_last_stage);
    assign w_illegal = (r_op > c_op_shra);

    // Stage k moves by 2^k; the rotate wrap-around uses the complement.
    assign w_step  = (LOG2W + 1)'(1) << r_stage;
    assign w_rstep = c_width - w_step;

    // State register
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  w_next_state = start ? S_RUN : S_IDLE;
            S_RUN:   w_next_state = w_last ? S_DONE : S_RUN;
            S_DONE:  w_next_state = start ? S_RUN : S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Status outputs decoded from the current state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_RUN:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // One stage of movement; illegal ops leave the operand untouched
    always_comb begin
        w_moved = r_work;
        case (r_op)
            c_op_rol:  w_moved = (r_work << w_step) | (r_work >> w_rstep);
            c_op_ror:  w_moved = (r_work >> w_step) | (r_work << w_rstep);
            c_op_shl:  w_moved = r_work << w_step;
            c_op_shr:  w_moved = r_work >> w_step;
            c_op_shra: w_moved = $signed(r_work) >>> w_step;
            default:   w_moved = r_work;
        endcase
    end

    assign w_stage_out = r_amt[r_stage] ? w_moved : r_work;

    // Final value: out-of-range shifts saturate to the fill pattern. The
    // arithmetic shift never alters the MSB, so r_work still holds the sign.
    always_comb begin
        w_final = w_stage_out;
        if (r_over) begin
            case (r_op)
                c_op_shl,
                c_op_shr:  w_final = '0;
                c_op_shra: w_final = {WIDTH{r_work[WIDTH-1]}};
                default:   w_final = w_stage_out;
            endcase
        end
    end

    // Datapath: capture on accept, step through stages, publish at the end
    always_ff @(posedge clk) begin
        if (clr) begin
            r_work   <= '0;
            r_op     <= '0;
            r_amt    <= '0;
            r_over   <= 1'b0;
            r_stage  <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_work  <= a;
            r_op    <= op;
            r_amt   <= b[LOG2W-1:0];
            r_over  <= |b[WIDTH-1:LOG2W];
            r_stage <= '0;
        end else if (r_state == S_RUN) begin
            r_work  <= w_stage_out;
            r_stage <= r_stage + LOG2W'(1);
            if (w_last) begin
                r_result <= w_final;
                r_err    <= w_illegal;
            end
        end
    end

    assign result = r_result;
    assign err    = r_err;

endmodule
`default_nettype wire
